// File: rtl/pixel_buf_pkg.sv
// Shared types and defaults for the ping-pong pixel buffer.
// Bank ownership states and the lane write-enable helper live here.
package pixel_buf_pkg;

    typedef enum logic [0:0] {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    localparam int unsigned LANES_DEF  = 3;
    localparam int unsigned LANE_W_DEF = 16;
    localparam int unsigned DEPTH_DEF  = 1024;
    localparam int unsigned MAX_LANES  = 32;

    // Turns active-low lane enables into an active-high write mask.
    function automatic logic [MAX_LANES-1:0] lane_mask(input logic [MAX_LANES-1:0] lane_n);
        return ~lane_n;
    endfunction

endpackage

// File: rtl/pixel_pingpong_buffer_if.sv
// Producer/consumer bus of the ping-pong pixel buffer.
// master = loader + PE array side, slave = the buffer itself.
interface pixel_pingpong_buffer_if #(
    parameter int unsigned LANES  = pixel_buf_pkg::LANES_DEF,
    parameter int unsigned LANE_W = pixel_buf_pkg::LANE_W_DEF,
    parameter int unsigned DEPTH  = pixel_buf_pkg::DEPTH_DEF
);
    localparam int unsigned W  = LANES * LANE_W;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             wr_en;
    logic [LANES-1:0] wr_lane_n;
    logic [AW-1:0]    wr_addr;
    logic [W-1:0]     wr_data;
    logic             wr_commit;
    logic             wr_ready;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic             rd_release;
    logic             rd_bank_ok;
    logic [W-1:0]     rd_data;
    logic             rd_valid;
    logic             err_sticky;

    modport master (
        output wr_en, wr_lane_n, wr_addr, wr_data, wr_commit,
        output rd_en, rd_addr, rd_release,
        input  wr_ready, rd_bank_ok, rd_data, rd_valid, err_sticky
    );

    modport slave (
        input  wr_en, wr_lane_n, wr_addr, wr_data, wr_commit,
        input  rd_en, rd_addr, rd_release,
        output wr_ready, rd_bank_ok, rd_data, rd_valid, err_sticky
    );

endinterface

// File: rtl/pixel_bank_ram.sv
// One pixel bank: 1W1R, DEPTH x W, per-lane active-low write enables.
// Read data is registered and holds until the next read; only the output register is reset.
module pixel_bank_ram #(
    parameter int unsigned LANES  = pixel_buf_pkg::LANES_DEF,
    parameter int unsigned LANE_W = pixel_buf_pkg::LANE_W_DEF,
    parameter int unsigned DEPTH  = pixel_buf_pkg::DEPTH_DEF,
    localparam int unsigned W     = LANES * LANE_W,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [LANES-1:0] lane_n,
    input  logic [AW-1:0]    waddr,
    input  logic [W-1:0]     wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [W-1:0]     q
);
    import pixel_buf_pkg::*;

    logic [W-1:0]     mem_r [DEPTH];
    logic [LANES-1:0] lane_we_s;

    assign lane_we_s = LANES'(lane_mask(MAX_LANES'(lane_n)));

    // Lane-masked write into the storage array.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_we_s[i]) begin
                    mem_r[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Registered read port with hold between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= {W{1'b0}};
        end else if (re) begin
            q <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/pixel_pingpong_buffer.sv
// Ping-pong pixel buffer: two banks handed between loader and PE array by commit/release.
// Holds bank ownership state, side pointers, read-data steering and the sticky error flag.
module pixel_pingpong_buffer #(
    parameter int unsigned LANES  = pixel_buf_pkg::LANES_DEF,
    parameter int unsigned LANE_W = pixel_buf_pkg::LANE_W_DEF,
    parameter int unsigned DEPTH  = pixel_buf_pkg::DEPTH_DEF
) (
    input logic                     clk,
    input logic                     rst,
    pixel_pingpong_buffer_if.slave  bus
);
    import pixel_buf_pkg::*;

    localparam int unsigned W  = LANES * LANE_W;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    bank_state_e  bank_state_r [2];
    logic         wr_bank_r;
    logic         rd_bank_r;
    logic         rd_sel_r;
    logic         rd_valid_r;
    logic         err_sticky_r;

    logic         wr_ready_s;
    logic         rd_bank_ok_s;
    logic         wr_addr_ok_s;
    logic         rd_addr_ok_s;
    logic         wr_acc_s;
    logic         commit_acc_s;
    logic         rd_acc_s;
    logic         release_acc_s;
    logic         err_s;
    logic [W-1:0] q_s [2];

    // Handshake flags look only at registered bank state so no input reaches them.
    assign wr_ready_s   = (bank_state_r[wr_bank_r] == BANK_EMPTY);
    assign rd_bank_ok_s = (bank_state_r[rd_bank_r] == BANK_FULL);

    // Acceptance and rejection decode for both sides.
    always_comb begin
        wr_addr_ok_s  = ({1'b0, bus.wr_addr} < DEPTH_L);
        rd_addr_ok_s  = ({1'b0, bus.rd_addr} < DEPTH_L);
        wr_acc_s      = bus.wr_en && wr_ready_s && wr_addr_ok_s;
        commit_acc_s  = bus.wr_commit && wr_ready_s;
        rd_acc_s      = bus.rd_en && rd_bank_ok_s && rd_addr_ok_s;
        release_acc_s = bus.rd_release && rd_bank_ok_s;
        err_s         = (bus.wr_en && !(wr_ready_s && wr_addr_ok_s))
                     || (bus.wr_commit && !wr_ready_s)
                     || (bus.rd_en && !(rd_bank_ok_s && rd_addr_ok_s))
                     || (bus.rd_release && !rd_bank_ok_s);
    end

    // Bank ownership, pointers, read strobe and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_state_r[0] <= BANK_EMPTY;
            bank_state_r[1] <= BANK_EMPTY;
            wr_bank_r       <= 1'b0;
            rd_bank_r       <= 1'b0;
            rd_sel_r        <= 1'b0;
            rd_valid_r      <= 1'b0;
            err_sticky_r    <= 1'b0;
        end else begin
            // Commit and release always target different banks, so both may apply at once.
            if (commit_acc_s) begin
                bank_state_r[wr_bank_r] <= BANK_FULL;
                wr_bank_r               <= ~wr_bank_r;
            end
            if (release_acc_s) begin
                bank_state_r[rd_bank_r] <= BANK_EMPTY;
                rd_bank_r               <= ~rd_bank_r;
            end
            rd_valid_r <= rd_acc_s;
            if (rd_acc_s) begin
                rd_sel_r <= rd_bank_r;
            end
            if (err_s) begin
                err_sticky_r <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pixel_bank_ram #(
            .LANES  (LANES),
            .LANE_W (LANE_W),
            .DEPTH  (DEPTH)
        ) u_ram (
            .clk    (clk),
            .rst    (rst),
            .we     (wr_acc_s && (wr_bank_r == 1'(b))),
            .lane_n (bus.wr_lane_n),
            .waddr  (bus.wr_addr),
            .wdata  (bus.wr_data),
            .re     (rd_acc_s && (rd_bank_r == 1'(b))),
            .raddr  (bus.rd_addr),
            .q      (q_s[b])
        );
    end

    // The bank read last keeps driving rd_data, which gives the hold behaviour.
    assign bus.rd_data    = q_s[rd_sel_r];
    assign bus.rd_valid   = rd_valid_r;
    assign bus.wr_ready   = wr_ready_s;
    assign bus.rd_bank_ok = rd_bank_ok_s;
    assign bus.err_sticky = err_sticky_r;

endmodule

// File: tb/tb_pixel_pingpong_buffer.sv
// Directed bench for pixel_pingpong_buffer: reads are scoreboarded through a queue,
// flags are compared inline against hand-computed values.
module tb_pixel_pingpong_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pixel_pingpong_buffer_if bus ();

    pixel_pingpong_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [47:0] exp_q [$];
    logic [47:0] exp_v;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wr_en      = 1'b0;
        bus.wr_lane_n  = 3'b111;
        bus.wr_addr    = 10'd0;
        bus.wr_data    = 48'd0;
        bus.wr_commit  = 1'b0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = 10'd0;
        bus.rd_release = 1'b0;
    endtask

    task automatic cyc(input logic we, input logic [2:0] ln, input logic [9:0] wa,
                       input logic [47:0] wd, input logic wc, input logic re,
                       input logic [9:0] ra, input logic rr);
        bus.wr_en      = we;
        bus.wr_lane_n  = ln;
        bus.wr_addr    = wa;
        bus.wr_data    = wd;
        bus.wr_commit  = wc;
        bus.rd_en      = re;
        bus.rd_addr    = ra;
        bus.rd_release = rr;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic wr(input logic [9:0] a, input logic [47:0] d, input logic [2:0] ln);
        cyc(1'b1, ln, a, d, 1'b0, 1'b0, 10'd0, 1'b0);
    endtask

    task automatic commit();
        cyc(1'b0, 3'b111, 10'd0, 48'd0, 1'b1, 1'b0, 10'd0, 1'b0);
    endtask

    task automatic release_bank();
        cyc(1'b0, 3'b111, 10'd0, 48'd0, 1'b0, 1'b0, 10'd0, 1'b1);
    endtask

    task automatic rd(input logic [9:0] a, input logic [47:0] exp);
        exp_q.push_back(exp);
        cyc(1'b0, 3'b111, 10'd0, 48'd0, 1'b0, 1'b1, a, 1'b0);
    endtask

    task automatic nop();
        cyc(1'b0, 3'b111, 10'd0, 48'd0, 1'b0, 1'b0, 10'd0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ready"},   48'(bus.wr_ready),   48'd1);
        check({tag, "_rd_bank_ok"}, 48'(bus.rd_bank_ok), 48'd0);
        check({tag, "_rd_valid"},   48'(bus.rd_valid),   48'd0);
        check({tag, "_rd_data"},    bus.rd_data,         48'd0);
        check({tag, "_err_sticky"}, 48'(bus.err_sticky), 48'd0);
    endtask

    // Scoreboard monitor: every rd_valid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got rd_data %h with rd_valid but no read outstanding", bus.rd_data);
            end else begin
                exp_v = exp_q.pop_front();
                check("rd_data", bus.rd_data, exp_v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no $finish expected completion");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Read with no full bank is rejected
        cyc(1'b0, 3'b111, 10'd0, 48'd0, 1'b0, 1'b1, 10'd0, 1'b0);
        check("rej_rd_valid",   48'(bus.rd_valid),   48'd0);
        check("rej_err_sticky", 48'(bus.err_sticky), 48'd1);
        check("rej_wr_ready",   48'(bus.wr_ready),   48'd1);
        check("rej_rd_bank_ok", 48'(bus.rd_bank_ok), 48'd0);

        // Full-word write, commit, read back; then hold check
        wr(10'd3, 48'h1234_5678_9ABC, 3'b000);
        commit();
        check("c0_rd_bank_ok", 48'(bus.rd_bank_ok), 48'd1);
        check("c0_wr_ready",   48'(bus.wr_ready),   48'd1);
        rd(10'd3, 48'h1234_5678_9ABC);
        nop();
        check("hold_rd_valid", 48'(bus.rd_valid), 48'd0);
        check("hold_rd_data",  bus.rd_data,       48'h1234_5678_9ABC);
        release_bank();
        check("r0_rd_bank_ok", 48'(bus.rd_bank_ok), 48'd0);

        // Lane mask on bank 1: only lane 0 updated over zero data
        wr(10'd3, 48'd0, 3'b000);
        wr(10'd3, 48'hFFFF_FFFF_FFFF, 3'b110);
        commit();
        rd(10'd3, 48'h0000_0000_FFFF);
        release_bank();
        check("both_empty_rd_bank_ok", 48'(bus.rd_bank_ok), 48'd0);

        // Clean reset to observe err_sticky again
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst2_err_sticky", 48'(bus.err_sticky), 48'd0);

        // Ping-pong: fill bank 0, then fill bank 1 while reading bank 0
        for (int i = 0; i < 8; i++) wr(10'(i), 48'(i), 3'b000);
        commit();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(48'(i));
            cyc(1'b1, 3'b000, 10'(i), 48'(100 + i), 1'b0, 1'b1, 10'(i), 1'b0);
        end
        commit();
        check("bp_wr_ready",   48'(bus.wr_ready),   48'd0);
        check("bp_err_before", 48'(bus.err_sticky), 48'd0);
        wr(10'd5, 48'hDEAD_BEEF_0000, 3'b000);
        check("bp_err_after",  48'(bus.err_sticky), 48'd1);
        release_bank();
        check("bp_wr_ready_rel", 48'(bus.wr_ready), 48'd1);
        for (int i = 0; i < 8; i++) rd(10'(i), 48'(100 + i));

        // Same-cycle commit (bank 0, unchanged) and release (bank 1)
        cyc(1'b0, 3'b111, 10'd0, 48'd0, 1'b1, 1'b0, 10'd0, 1'b1);
        check("swap_wr_ready",   48'(bus.wr_ready),   48'd1);
        check("swap_rd_bank_ok", 48'(bus.rd_bank_ok), 48'd1);
        rd(10'd5, 48'd5);
        rd(10'd0, 48'd0);

        // Reset asserted mid-fill while a read result is on the outputs
        exp_q.push_back(48'd5);
        cyc(1'b1, 3'b000, 10'd1, 48'h0000_0000_ABCD, 1'b0, 1'b1, 10'd5, 1'b0);
        check("pre_rst_rd_valid", 48'(bus.rd_valid), 48'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // After reset both pointers are back at bank 0; all-ones lane_n is a no-op
        wr(10'd0, 48'd77, 3'b000);
        wr(10'd0, 48'hFFFF_FFFF_FFFF, 3'b111);
        commit();
        check("post_rst_rd_bank_ok", 48'(bus.rd_bank_ok), 48'd1);
        rd(10'd0, 48'd77);
        nop();
        nop();

        check("scoreboard_drained", 48'(exp_q.size()), 48'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
